// File: rtl/point_mult.sv
// point_mult: scalar point multiplier R = k*P using left-to-right double-and-add,
// sequencing an external point adder and doubler through their held-reset/Done handshake.
module point_mult #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] Px,
    input  logic [WIDTH-1:0] Py,
    output logic             busy,
    output logic             Done,
    output logic             inf,
    output logic [WIDTH-1:0] Rx,
    output logic [WIDTH-1:0] Ry,
    output logic             add_Reset,
    output logic [WIDTH-1:0] add_Px,
    output logic [WIDTH-1:0] add_Py,
    output logic [WIDTH-1:0] add_Qx,
    output logic [WIDTH-1:0] add_Qy,
    input  logic             add_Done,
    input  logic [WIDTH-1:0] add_Rx,
    input  logic [WIDTH-1:0] add_Ry,
    output logic             dbl_Reset,
    output logic [WIDTH-1:0] dbl_Px,
    output logic [WIDTH-1:0] dbl_Py,
    input  logic             dbl_Done,
    input  logic [WIDTH-1:0] dbl_Rx,
    input  logic [WIDTH-1:0] dbl_Ry
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD_CHK, ADD, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] kr_q, kr_d, pxr_q, pxr_d, pyr_q, pyr_d;
    logic [WIDTH-1:0] ax_q, ax_d, ay_q, ay_d;
    logic             ainf_q, ainf_d, dsrc_q, dsrc_d, skip_q, skip_d;
    logic [IW-1:0]    i_q, i_d;
    logic             kbit, last;
    state_t           step_state;
    logic [IW-1:0]    step_i;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            kr_q    <= '0;
            pxr_q   <= '0;
            pyr_q   <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            ainf_q  <= 1'b0;
            dsrc_q  <= 1'b0;
            skip_q  <= 1'b0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            kr_q    <= kr_d;
            pxr_q   <= pxr_d;
            pyr_q   <= pyr_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            ainf_q  <= ainf_d;
            dsrc_q  <= dsrc_d;
            skip_q  <= skip_d;
            i_q     <= i_d;
        end
    end

    assign kbit       = kr_q[i_q];
    assign last       = (i_q == '0);
    assign step_state = last ? FIN : SCAN;
    assign step_i     = last ? i_q : i_q - IW'(1);

    // skip_q masks the first cycle of DBL/ADD, when the sub-block is only just leaving reset
    always_comb begin
        state_d = state_q;
        kr_d    = kr_q;
        pxr_d   = pxr_q;
        pyr_d   = pyr_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        ainf_d  = ainf_q;
        dsrc_d  = dsrc_q;
        skip_d  = skip_q;
        i_d     = i_q;
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    kr_d    = k;
                    pxr_d   = Px;
                    pyr_d   = Py;
                    ainf_d  = 1'b1;
                    dsrc_d  = 1'b0;
                    i_d     = IW'(WIDTH - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ainf_q) begin
                    if (kbit) begin
                        ax_d   = pxr_q;
                        ay_d   = pyr_q;
                        ainf_d = 1'b0;
                    end
                    state_d = step_state;
                    i_d     = step_i;
                end else if (ay_q == '0) begin
                    ainf_d  = 1'b1;
                    state_d = ADD_CHK;
                end else begin
                    dsrc_d  = 1'b0;
                    skip_d  = 1'b1;
                    state_d = DBL;
                end
            end
            DBL: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (dbl_Done) begin
                    ax_d    = dbl_Rx;
                    ay_d    = dbl_Ry;
                    state_d = dsrc_q ? step_state : ADD_CHK;
                    i_d     = dsrc_q ? step_i : i_q;
                end
            end
            ADD_CHK: begin
                if (!kbit) begin
                    state_d = step_state;
                    i_d     = step_i;
                end else if (ainf_q) begin
                    ax_d    = pxr_q;
                    ay_d    = pyr_q;
                    ainf_d  = 1'b0;
                    state_d = step_state;
                    i_d     = step_i;
                end else if (ax_q != pxr_q) begin
                    skip_d  = 1'b1;
                    state_d = ADD;
                end else if (ay_q == pyr_q && ay_q != '0) begin
                    dsrc_d  = 1'b1;
                    skip_d  = 1'b1;
                    state_d = DBL;
                end else begin
                    ainf_d  = 1'b1;
                    state_d = step_state;
                    i_d     = step_i;
                end
            end
            ADD: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (add_Done) begin
                    ax_d    = add_Rx;
                    ay_d    = add_Ry;
                    state_d = step_state;
                    i_d     = step_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE) && (state_q != FIN);
    assign Done      = (state_q == FIN);
    assign inf       = Done && ainf_q;
    assign Rx        = (Done && !ainf_q) ? ax_q : '0;
    assign Ry        = (Done && !ainf_q) ? ay_q : '0;
    assign add_Reset = (state_q != ADD);
    assign add_Px    = ax_q;
    assign add_Py    = ay_q;
    assign add_Qx    = pxr_q;
    assign add_Qy    = pyr_q;
    assign dbl_Reset = (state_q != DBL);
    assign dbl_Px    = dsrc_q ? pxr_q : ax_q;
    assign dbl_Py    = dsrc_q ? pyr_q : ay_q;
endmodule

// File: tb/tb_point_mult.sv
// tb_point_mult: directed bench for point_mult on y^2=x^3+2x+2 mod 17 with
// behavioural adder/doubler stubs and a scoreboard of expected results.
module tb_point_mult;
    localparam int WIDTH = 256;

    typedef struct packed {
        bit inf;
        int x;
        int y;
    } pt_t;

    logic             clk = 1'b0;
    logic             Reset_n, start;
    logic [WIDTH-1:0] k, Px, Py;
    logic             busy, Done, inf;
    logic [WIDTH-1:0] Rx, Ry;
    logic             add_Reset, add_Done, dbl_Reset, dbl_Done;
    logic [WIDTH-1:0] add_Px, add_Py, add_Qx, add_Qy, add_Rx, add_Ry;
    logic [WIDTH-1:0] dbl_Px, dbl_Py, dbl_Rx, dbl_Ry;

    int  total = 0, bad = 0;
    int  add_cnt = 0, dbl_cnt = 0;
    int  add_l = 0, dbl_l = 0, overlap = 0;
    bit  add_prev = 1'b1, dbl_prev = 1'b1;
    pt_t exp_q[$];
    pt_t sa, sd;

    always #5 clk = ~clk;

    point_mult #(.WIDTH(WIDTH)) dut (
        .clk(clk), .Reset_n(Reset_n), .start(start), .k(k), .Px(Px), .Py(Py),
        .busy(busy), .Done(Done), .inf(inf), .Rx(Rx), .Ry(Ry),
        .add_Reset(add_Reset), .add_Px(add_Px), .add_Py(add_Py), .add_Qx(add_Qx), .add_Qy(add_Qy),
        .add_Done(add_Done), .add_Rx(add_Rx), .add_Ry(add_Ry),
        .dbl_Reset(dbl_Reset), .dbl_Px(dbl_Px), .dbl_Py(dbl_Py),
        .dbl_Done(dbl_Done), .dbl_Rx(dbl_Rx), .dbl_Ry(dbl_Ry)
    );

    function automatic int md(int a);
        return ((a % 17) + 17) % 17;
    endfunction

    function automatic int inv(int a);
        int r = 1;
        for (int n = 0; n < 15; n++) r = md(r * a);
        return r;
    endfunction

    function automatic pt_t mk(bit i, int x, int y);
        pt_t p;
        p.inf = i;
        p.x = x;
        p.y = y;
        return p;
    endfunction

    function automatic pt_t padd(pt_t a, pt_t b);
        int l, x3;
        if (a.inf) return b;
        if (b.inf) return a;
        if (a.x == b.x) begin
            if (md(a.y + b.y) == 0) return mk(1'b1, 0, 0);
            l = md(md(3 * a.x * a.x + 2) * inv(md(2 * a.y)));
        end else begin
            l = md(md(b.y - a.y) * inv(md(b.x - a.x)));
        end
        x3 = md(l * l - a.x - b.x);
        return mk(1'b0, x3, md(l * (a.x - x3) - a.y));
    endfunction

    // reference: k repeated additions of P, independent of the bit-serial order
    function automatic pt_t kmul(int kv);
        pt_t r = mk(1'b1, 0, 0);
        for (int n = 0; n < kv; n++) r = padd(r, mk(1'b0, 5, 1));
        return r;
    endfunction

    always @(posedge clk) begin
        add_cnt <= add_Reset ? 0 : (add_cnt < 5 ? add_cnt + 1 : add_cnt);
        dbl_cnt <= dbl_Reset ? 0 : (dbl_cnt < 5 ? dbl_cnt + 1 : dbl_cnt);
    end

    always_comb begin
        sa = padd(mk(1'b0, int'(add_Px[7:0]), int'(add_Py[7:0])), mk(1'b0, int'(add_Qx[7:0]), int'(add_Qy[7:0])));
        sd = padd(mk(1'b0, int'(dbl_Px[7:0]), int'(dbl_Py[7:0])), mk(1'b0, int'(dbl_Px[7:0]), int'(dbl_Py[7:0])));
    end

    assign add_Done = (add_cnt == 5);
    assign dbl_Done = (dbl_cnt == 5);
    assign add_Rx   = WIDTH'(sa.x);
    assign add_Ry   = WIDTH'(sa.y);
    assign dbl_Rx   = WIDTH'(sd.x);
    assign dbl_Ry   = WIDTH'(sd.y);

    always @(negedge clk) begin
        if (add_prev && !add_Reset) add_l <= add_l + 1;
        if (dbl_prev && !dbl_Reset) dbl_l <= dbl_l + 1;
        if (!add_Reset && !dbl_Reset) overlap <= overlap + 1;
        add_prev <= add_Reset;
        dbl_prev <= dbl_Reset;
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int kv);
        @(negedge clk);
        Px = 5;
        Py = 1;
        k = WIDTH'(kv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = '1;
        Px = 0;
        Py = 0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        pt_t e;
        cyc = 1;
        while (!Done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!Done) begin
            chk({tag, "_timeout"}, Done, 1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_done"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_inf"}, inf, e.inf);
            chk({tag, "_Rx"}, Rx, e.inf ? 0 : e.x);
            chk({tag, "_Ry"}, Ry, e.inf ? 0 : e.y);
        end
    endtask

    task automatic run(input string tag, input int kv, output int cyc);
        do_start(kv);
        exp_q.push_back(kmul(kv));
        chk({tag, "_busy"}, busy, 1);
        wait_done(tag, cyc);
    endtask

    initial begin
        int c, a0, d0;
        start = 1'b0;
        k = '0;
        Px = 5;
        Py = 1;
        Reset_n = 1'b1;
        #3 Reset_n = 1'b0;
        #4;
        chk("rst_busy", busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_inf", inf, 0);
        chk("rst_Rx", Rx, 0);
        chk("rst_Ry", Ry, 0);
        chk("rst_add_Reset", add_Reset, 1);
        chk("rst_dbl_Reset", dbl_Reset, 1);
        chk("rst_add_Px", add_Px, 0);
        chk("rst_dbl_Px", dbl_Px, 0);
        @(negedge clk);
        Reset_n = 1'b1;

        a0 = add_l; d0 = dbl_l;
        run("k0", 0, c);
        chk("k0_cycles", c, 257);
        chk("k0_adds", add_l - a0, 0);
        chk("k0_dbls", dbl_l - d0, 0);

        a0 = add_l; d0 = dbl_l;
        run("k1", 1, c);
        chk("k1_cycles", c, 257);
        chk("k1_adds", add_l - a0, 0);
        chk("k1_dbls", dbl_l - d0, 0);

        a0 = add_l; d0 = dbl_l;
        run("k2", 2, c);
        chk("k2_adds", add_l - a0, 0);
        chk("k2_dbls", dbl_l - d0, 1);

        a0 = add_l; d0 = dbl_l;
        run("k3", 3, c);
        chk("k3_adds", add_l - a0, 1);
        chk("k3_dbls", dbl_l - d0, 1);

        run("k19", 19, c);
        run("k20", 20, c);

        do_start(3);
        exp_q.push_back(kmul(3));
        repeat (10) @(posedge clk);
        @(negedge clk);
        k = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore", busy, 1);
        wait_done("k3_busy", c);
        do_start(2);
        exp_q.push_back(kmul(2));
        chk("fin_start_done_drop", Done, 0);
        chk("fin_start_busy", busy, 1);
        wait_done("k2_restart", c);

        do_start(3);
        c = 0;
        while (add_Reset && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("mid_add_running", add_Reset, 0);
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_add_Reset", add_Reset, 1);
        chk("mid_rst_dbl_Reset", dbl_Reset, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", Done, 0);
        chk("mid_rst_Rx", Rx, 0);
        chk("mid_rst_add_Px", add_Px, 0);
        @(negedge clk);
        Reset_n = 1'b1;
        run("k2_after_rst", 2, c);

        chk("reset_overlap", overlap, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/point_mult.md
# point_mult

Scalar point multiplier, R = k·P, by left-to-right double-and-add over a 256-bit scalar. It sits directly upstream of the point adder and the point doubler and drives both through their held-reset/Done handshake: it supplies their operands and latches their results. It also handles the point at infinity and the special cases the adder cannot compute (equal x-coordinates). The adder and doubler are instantiated outside this block and reached through the `add_*` and `dbl_*` ports.

## Interface
- WIDTH, 256, coordinate and scalar width in bits.
- clk  in  1  clock; all logic is rising-edge.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or FIN.
- k  in  WIDTH  scalar; latched on start.
- Px, Py  in  WIDTH  affine base point (never infinity); latched on start.
- busy  out  1  high from the cycle after start until FIN.
- Done  out  1  level; high in FIN, cleared when the next start is accepted.
- inf  out  1  result is the point at infinity (valid while Done=1).
- Rx, Ry  out  WIDTH  result coordinates; 0 when inf=1; valid while Done=1.
- add_Reset  out  1  adder hold; 1 = held/cleared, 0 = run.
- add_Px, add_Py, add_Qx, add_Qy  out  WIDTH  adder operands, in the order (acc, P).
- add_Done  in  1  adder finished (level).
- add_Rx, add_Ry  in  WIDTH  adder result.
- dbl_Reset  out  1  doubler hold; same polarity as add_Reset.
- dbl_Px, dbl_Py  out  WIDTH  doubler operand.
- dbl_Done  in  1  doubler finished (level).
- dbl_Rx, dbl_Ry  in  WIDTH  doubler result.

## Operation
- **Registers:**
  - accumulator (ax, ay, ainf);
  - latched kr, pxr, pyr;
  - bit index i, a log2(WIDTH)-bit down-counter;
  - flag dsrc, set when the doubler is run on P instead of on acc.
- **Step operation:** if i==0, go to FIN; else decrement i and go to SCAN.
- **States:**
  - **IDLE:** on start, latch k, Px and Py; ainf=1; i=WIDTH-1; go to SCAN.
  - **SCAN:**
    - If ainf=1: when kr[i]=1, load acc=P and ainf=0. Then step. There is no doubling while acc is infinity.
    - If ainf=0 and ay==0: set ainf=1 (2·acc is infinity) and go to ADD_CHK.
    - Otherwise clear dsrc and go to DBL with operand acc.
  - **DBL:** dbl_Reset=0; operands come from registers and are stable for the whole state. Wait for dbl_Done=1, ignoring the first cycle in the state. Then acc = (dbl_Rx, dbl_Ry). If dsrc=1, step; else go to ADD_CHK.
  - **ADD_CHK:**
    - kr[i]=0: step.
    - kr[i]=1 and ainf=1: acc=P, ainf=0, step.
    - ax≠pxr: go to ADD.
    - ax==pxr, ay==pyr, ay≠0: dsrc=1, go to DBL with operand P.
    - Any other ax==pxr case: ainf=1 (acc = −P, or a y=0 double), step.
  - **ADD:** add_Reset=0; wait for add_Done as in DBL; acc = (add_Rx, add_Ry); step.
  - **FIN:** Done=1; Rx/Ry/inf reflect acc, with Rx=Ry=0 when ainf=1. On start, re-latch inputs and go to SCAN. Otherwise hold indefinitely.
- **Sub-block control:** add_Reset and dbl_Reset are 1 in every state except ADD and DBL respectively. This guarantees each sub-block sees at least one reset cycle between launches.
- **start handling:** ignored while busy. k and P changes after start have no effect.
- **Equality compares** are full WIDTH-bit. This block performs no modular arithmetic.

## Timing
- **Reset values:**
  - state = IDLE;
  - busy, Done, inf = 0;
  - Rx, Ry and all operand outputs = 0;
  - add_Reset = dbl_Reset = 1;
  - internal registers = 0.
- **Asynchronous reset mid-operation:** returns to IDLE immediately. The sub-blocks are forced back to hold via their reset ports. No Done is produced.
- **Start cycle:** start is sampled at edge 0. busy=1 from cycle 1, with state=SCAN, i=WIDTH-1.
- **Cycles per bit:**
  - While ainf=1: 1 cycle per bit.
  - Otherwise: 1 (SCAN) + (tD+1) (DBL) + 1 (ADD_CHK), plus (tA+1) when ADD runs.
  - tD and tA are the sub-block Done latencies.
- **k=0:** Done=1 at cycle WIDTH+1 after the start edge.
- **Done behaviour:** Done rises on entry to FIN, at the same edge as the final acc update and busy falling. A start in FIN clears Done on the next edge.
- **Result latching:** results are captured on the edge where Done=1 is seen. Sub-block results need not stay valid afterwards.

## Test plan
Curve y²=x³+2x+2 mod 17, P=(5,1), order 19. The adder and doubler stubs are mod-17 behavioural models with Done latency 5 cycles, zero-extended to 256 bits.

- **k=0:** Done at cycle 257 after start, inf=1, Rx=Ry=0, zero add/dbl launches.
- **k=1:** Rx=5, Ry=1, inf=0, Done at cycle 257, no launches.
- **k=2 → (6,3) and k=3 → (10,6):** 1 dbl launch for k=2; 1 dbl + 1 add launch for k=3. add_Reset and dbl_Reset are never both 0.
- **k=19 → inf=1:** the final ADD_CHK sees 18P=(5,16) vs P=(5,1), takes the equal-x/unequal-y path, and launches no add. With k=20, the result is (5,1).
- **Start while busy:** pulse start with k=2 while running k=3 → ignored, result (10,6). Then start k=2 in FIN → Done drops next cycle, new result (6,3).
- **Reset mid-operation:** assert Reset_n low during an ADD of k=3. All outputs take reset values within the same cycle and add_Reset=1. After release, a new start k=2 gives (6,3).
